// File: rtl/ones_cnt_oneh.sv
// rtl/ones_cnt_oneh.sv - parametrised ones/zeros counter with one-hot control unit
module ones_cnt_oneh #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             abort,
  output logic             rdy,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic [4:0]       state_oh
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_INCR  = 5'b00010,
    S_SHIFT = 5'b00100,
    S_CHECK = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  // Kept as a plain vector so any of the 32 encodings can be held and recovered from.
  logic [4:0]       state;
  logic [WIDTH-1:0] r1;
  logic [CNT_W-1:0] r2;
  logic             e;
  logic             zero;
  logic [CNT_W-1:0] r2_inc;

  assign zero   = (r1 == '0);
  assign r2_inc = r2 + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      r1     <= '0;
      r2     <= '0;
      e      <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r1    <= mode ? ~data_in : data_in;
            r2    <= '1;
            state <= S_INCR;
          end
        end
        S_INCR: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            r2 <= r2_inc;
            if (zero) begin
              result <= r2_inc;
              state  <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            {e, r1} <= {r1, 1'b0};
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort)  state <= S_IDLE;
          else if (e) state <= S_INCR;
          else        state <= S_SHIFT;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rdy      = state[0];
  assign busy     = |state[4:1];
  assign done     = state[4];
  assign state_oh = state;

endmodule

// File: doc/ones_cnt_oneh.md
# ones_cnt_oneh

Parametrised ones/zeros counter with a one-hot control unit and its own datapath. It is the next generation of our one-hot counting controller. The operand width is now a parameter, the shift register and counter are internal, and the block adds a count-zeros mode, an abort input, a registered result with a done pulse, and recovery from illegal one-hot states. It sits as a slave accelerator behind a start/rdy/done handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), width of the counter and the result. Derived; do not override.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a count. Sampled only in IDLE.
- mode  input  1  0 = count ones, 1 = count zeros. Sampled with start.
- data_in  input  WIDTH  operand. Sampled with start.
- abort  input  1  cancel an operation in progress. Ignored in IDLE.
- rdy  output  1  high in IDLE.
- busy  output  1  high in INCR, SHIFT, CHECK and DONE.
- done  output  1  one-cycle pulse, high in DONE.
- result  output  CNT_W  last completed count. Registered.
- state_oh  output  5  one-hot state vector for debug. Bit0=IDLE, bit1=INCR, bit2=SHIFT, bit3=CHECK, bit4=DONE.

## Operation
- Internal registers:
  - R1[WIDTH]: shift register holding the operand.
  - R2[CNT_W]: counter.
  - E: the bit shifted out of R1.
  - zero: combinational flag, R1 == 0.
- The state register is one flip-flop per state. IDLE resets to 1 and all others reset to 0.
- IDLE:
  - With start=1, load R1 ← mode ? ~data_in : data_in and R2 ← all ones, then go to INCR.
  - Otherwise stay in IDLE.
- INCR: R2 ← R2 + 1, wrapping modulo 2^CNT_W. Go to DONE if zero, else to SHIFT.
- SHIFT: {E, R1} ← {R1, 1'b0}. Go to CHECK.
- CHECK: go to INCR if E, else to SHIFT.
- DONE: result ← R2 on entry, i.e. at the INCR→DONE edge. Go to IDLE.
- abort=1 in INCR, SHIFT or CHECK: go to IDLE on the next edge.
  - result is unchanged and done does not fire.
  - abort has priority over all other transitions.
- abort in DONE has no effect; DONE always completes.
- start is ignored outside IDLE. It is level-sensitive: if start is still high in IDLE after DONE, a new operation begins.
- Illegal state vector (not exactly one bit set): force IDLE on the next edge. R1, R2, E and result are untouched.
- result always fits: the maximum count is WIDTH < 2^CNT_W.

## Timing
- Reset values:
  - State: IDLE (state_oh = 5'b00001).
  - Registers: R1 = 0, R2 = 0, E = 0, result = 0.
  - Outputs: rdy = 1, busy = 0, done = 0.
- rdy, busy, done and state_oh are decoded from state flops only. They are glitch-free, with no input-to-output combinational paths.
- Notation for a counted operand (after mode inversion):
  - p = popcount.
  - t = trailing-zero count, with t = WIDTH when the operand is 0.
  - s = WIDTH − t, the number of shifts.
- Latency: with start accepted at edge k, DONE is entered at edge k + (p+1) + 2s. done is high for that one cycle, and rdy returns at the following edge.
- Throughput: back-to-back operations have no extra idle gap beyond the one IDLE cycle needed to sample start.
- rst asserted mid-operation: everything returns to reset values immediately (asynchronous). No done pulse is produced.

## Test plan
- Reset mid-operation: with WIDTH=8, start with data_in=8'hFF and assert rst at cycle 5 → state_oh=5'b00001, result=0 and done=0 immediately, with no done pulse afterwards.
- Zero operand: WIDTH=8, mode=0, data_in=8'h00 → DONE entered 1 cycle after accept; result=0; done exactly one cycle wide.
- Single bit at each end (WIDTH=8, mode=0):
  - data_in=8'h80 → result=1 after 4 cycles.
  - data_in=8'h01 → result=1 after 18 cycles.
- All ones and count-zeros mode:
  - WIDTH=8, data_in=8'hFF, mode=0 → result=8 after 25 cycles.
  - Same operand with mode=1 → result=0 after 1 cycle.
  - WIDTH=16, data_in=16'h00F0, mode=1 → result=12.
- Abort and start rules:
  - Start with 8'hA5, then pulse abort in SHIFT → IDLE next edge; result keeps its previous value; no done.
  - start pulsed while busy → ignored.
- Illegal state recovery: force state_oh=5'b00110 → IDLE next edge. A following start with 8'h0F yields result=4.
